fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupled instruction fetch front end.
- Issues PC-sequential requests to instruction memory over a req/gnt/rvalid handshake and buffers returned instructions in an in-order queue.
- Presents {instr, pc, pc+4} to the IF/ID register with valid/ready.
- Redirects to a new PC on branch/jump resolution, discarding stale in-flight responses.

Parameters:
- DATA_WIDTH, 64, PC/address width.
- INSTR_WIDTH, 32, instruction width.
- DEPTH, 4, queue entries; also bounds queued + in-flight requests (power of two, ≥2).
- PC_START_ADDR, 64'h0, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- redirect_i  in  1  taken branch/jump from execute (PCSrcE).
- redirect_pc_i  in  DATA_WIDTH  redirect target (PCTargetE).
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  DATA_WIDTH  fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rdata_i  in  INSTR_WIDTH  response instruction.
- instr_valid_o  out  1  queue head valid.
- instr_o  out  INSTR_WIDTH  head instruction.
- pc_o  out  DATA_WIDTH  head PC.
- pc_4_o  out  DATA_WIDTH  head PC + 4.
- instr_ready_i  in  1  decode accepts head (= !StallD).

Behaviour:
- Reset values (async, immediate):
  - fetch_pc = resp_pc = PC_START_ADDR.
  - inflight = discard_cnt = 0; queue empty.
  - imem_req_o = 0, instr_valid_o = 0.
  - instr_o, pc_o, pc_4_o = 0.
- Request issue:
  - imem_req_o = !redirect_i && (q_count + inflight < DEPTH).
  - imem_addr_o = fetch_pc.
  - On req && gnt: fetch_pc += 4 (wraps modulo 2^DATA_WIDTH), inflight++.
  - req held with a stable address until gnt.
- Response:
  - On rvalid: inflight--.
  - If discard_cnt > 0: discard_cnt--, data dropped.
  - Else push {rdata, resp_pc}; resp_pc += 4.
  - rvalid while inflight == 0 is ignored; no state change.
- Output:
  - Head is combinational from the queue; pc_4_o = pc_o + 4.
  - Pop on instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle keep q_count unchanged.
  - Push into an empty queue is visible the next cycle; latency rvalid→instr_valid_o is 1 cycle.
- Full/empty:
  - The credit rule guarantees no overflow.
  - Pop on empty is suppressed.
  - Push on full is impossible; an assertion flags it.
- Redirect (single-cycle pulse, highest priority):
  - Queue flushed; a pop in that cycle is ignored.
  - No request issued.
  - fetch_pc = resp_pc = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}.
  - discard_cnt = inflight − (imem_rvalid_i ? 1 : 0); the response arriving this cycle is dropped regardless.
  - New requests are allowed the following cycle, while stale responses are still being discarded.
- Back-to-back redirects: each one recomputes discard_cnt from the current inflight; the last target wins.
- Reset mid-operation clears all counters. The memory is reset by the same rst_i, so no responses are owed afterwards.
- Counter widths: $clog2(DEPTH)+1 bits for q_count, inflight and discard_cnt.

Decomposition:
- fetch_pkg:
  - fetch_entry_t struct {instr[INSTR_WIDTH], pc[DATA_WIDTH]}.
  - FETCH_DEPTH default.
  - PC_STEP = 4.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count. Flush has priority over push/pop. Count is async-reset to 0.
- Top level holds the PC/credit/discard logic.

Test Plan:
- Reset, PC_START_ADDR = 0x1000, gnt = 1, latency 1, ready = 1 → addresses 0x1000, 0x1004, 0x1008…; first instr_valid_o on cycle 3 with pc_o = 0x1000 and pc_4_o = 0x1004; one instruction per cycle afterwards.
- ready = 0 held for 10 cycles, latency 1 → exactly 4 entries queued, imem_req_o low after 4 grants. Release ready → PCs 0x1000–0x100C delivered in order, then fetch resumes at 0x1010.
- Latency 3 with 3 requests in flight; redirect to 0x2002 while a response arrives → discard_cnt = 2, queue empty. Next request address 0x2000; the first delivered pc_o is 0x2000, and the three stale responses never appear.
- gnt held low 5 cycles → imem_addr_o stable at 0x1000 with req high; no queue change.
- Redirect on two consecutive cycles (0x3000, then 0x4000) → only 0x4000-stream instructions delivered.
- Assert rst_i asynchronously mid-stream with a full queue → outputs drop to zero within the same cycle; after release, fetch restarts at PC_START_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int FETCH_DEPTH   = 4;
    localparam int FETCH_DATA_W  = 64;
    localparam int FETCH_INSTR_W = 32;
    localparam int PC_STEP       = 4;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_DATA_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched instructions; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = FETCH_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A push into a full queue is only safe when the head leaves the same cycle.
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: sequential PC requests, credit-limited, with
// redirect that flushes the queue and drops responses owed to the old stream.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH    = FETCH_DATA_W,
    parameter int                    INSTR_WIDTH   = FETCH_INSTR_W,
    parameter int                    DEPTH         = FETCH_DEPTH,
    parameter logic [DATA_WIDTH-1:0] PC_START_ADDR = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   redirect_i,
    input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
    output logic                   imem_req_o,
    output logic [DATA_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0]  pc_o,
    output logic [DATA_WIDTH-1:0]  pc_4_o,
    input  logic                   instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0]  pc;
    } entry_t;

    logic [DATA_WIDTH-1:0] fetch_pc, resp_pc, redirect_base;
    logic [CW-1:0]         inflight, discard_cnt, q_count;
    logic [CW:0]           credit_used;
    logic                  q_full, q_empty;
    logic                  grant, rsp_take, push, pop;
    entry_t                push_entry, head;

    // Queued entries plus outstanding requests never exceed DEPTH, so every
    // response always has a slot waiting for it.
    assign credit_used   = {1'b0, q_count} + {1'b0, inflight};
    assign imem_req_o    = !rst_i && !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o   = fetch_pc;
    assign grant         = imem_req_o && imem_gnt_i;
    assign rsp_take      = imem_rvalid_i && (inflight != '0);
    assign push          = rsp_take && !redirect_i && (discard_cnt == '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign redirect_base = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

    assign push_entry.instr = imem_rdata_i;
    assign push_entry.pc    = resp_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc    <= PC_START_ADDR;
            resp_pc     <= PC_START_ADDR;
            inflight    <= '0;
            discard_cnt <= '0;
        end else if (redirect_i) begin
            // Everything still owed belongs to the old stream, minus the
            // response consumed (and dropped) right now.
            fetch_pc    <= redirect_base;
            resp_pc     <= redirect_base;
            inflight    <= inflight - CW'(rsp_take);
            discard_cnt <= inflight - CW'(rsp_take);
        end else begin
            if (grant) fetch_pc <= fetch_pc + STEP;
            inflight <= inflight + CW'(grant) - CW'(rsp_take);
            if (rsp_take) begin
                if (discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
                else                   resp_pc     <= resp_pc + STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign instr_valid_o = !q_empty;
    assign instr_o       = instr_valid_o ? head.instr       : '0;
    assign pc_o          = instr_valid_o ? head.pc          : '0;
    assign pc_4_o        = instr_valid_o ? head.pc + STEP   : '0;

    assert property (@(posedge clk_i) disable iff (rst_i) !(push && q_full && !pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench: epoch-tagged memory model feeds a scoreboard of expected
// {instr, pc}; a monitor compares every accepted head and every request.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DW    = 64;
    localparam int          IW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [63:0] START = 64'h1000;
    localparam int          BIG   = 32'h3fff_ffff;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          redirect_i = 1'b0;
    logic [DW-1:0] redirect_pc_i = '0;
    logic          imem_req_o;
    logic [DW-1:0] imem_addr_o;
    logic          imem_gnt_i = 1'b0;
    logic          imem_rvalid_i = 1'b0;
    logic [IW-1:0] imem_rdata_i = '0;
    logic          instr_valid_o;
    logic [IW-1:0] instr_o;
    logic [DW-1:0] pc_o, pc_4_o;
    logic          instr_ready_i = 1'b0;

    always #5 clk_i = ~clk_i;

    fetch_queue #(
        .DATA_WIDTH(DW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .PC_START_ADDR(START)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o), .pc_4_o(pc_4_o),
        .instr_ready_i(instr_ready_i)
    );

    typedef struct { logic [63:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] instr; logic [63:0] pc; } exp_t;

    req_t pend[$];     // requests granted, response not yet returned
    exp_t exp_q[$];    // instructions the DUT owes to decode, in order
    int   checks = 0, failures = 0;
    int   cyc = 0, epoch = 0, grants = 0, delivered = 0;
    logic [63:0] model_pc = START;

    // stimulus knobs
    int          gnt_budget = BIG, gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    bit          redir_on_rsp = 1'b0;
    logic [63:0] redir_on_rsp_tgt = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Memory + control driver, one call per cycle on the falling edge.
    task automatic drive_cycle(input bit redir = 1'b0, input logic [63:0] tgt = '0);
        @(negedge clk_i);
        imem_gnt_i    = (grants < gnt_budget) && (int'($urandom_range(99)) < gnt_pct);
        instr_ready_i = int'($urandom_range(99)) < rdy_pct;
        imem_rvalid_i = !rst_i && (pend.size() != 0) && (pend[0].due <= cyc);
        imem_rdata_i  = imem_rvalid_i ? mem_word(pend[0].addr) : $urandom;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        if (redir_on_rsp && imem_rvalid_i) begin
            redirect_i    = 1'b1;
            redirect_pc_i = redir_on_rsp_tgt;
            redir_on_rsp  = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        repeat (2) drive_cycle();
        rst_i = 1'b0;
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    initial begin
        exp_t e;
        req_t r;
        forever begin
            @(negedge clk_i);
            #4;
            if (rst_i) begin
                pend.delete();
                exp_q.delete();
                model_pc = START;
            end else begin
                chk("instr_valid", 64'(instr_valid_o), 64'(exp_q.size() != 0));
                chk("imem_req", 64'(imem_req_o),
                    64'(!redirect_i && (exp_q.size() + pend.size() < DEPTH)));
                if (redirect_i) begin
                    if (imem_rvalid_i && pend.size() != 0) void'(pend.pop_front());
                    exp_q.delete();
                    epoch++;
                    model_pc = {redirect_pc_i[63:2], 2'b00};
                end else begin
                    if (instr_valid_o && instr_ready_i && exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("pc_o", pc_o, e.pc);
                        chk("pc_4_o", pc_4_o, e.pc + 64'd4);
                        chk("instr_o", 64'(instr_o), 64'(e.instr));
                        delivered++;
                    end
                    if (imem_rvalid_i && pend.size() != 0) begin
                        r = pend.pop_front();
                        if (r.epoch == epoch) exp_q.push_back('{instr: mem_word(r.addr), pc: r.addr});
                    end
                    if (imem_req_o && imem_gnt_i) begin
                        chk("imem_addr", imem_addr_o, model_pc);
                        pend.push_back('{addr: model_pc, epoch: epoch,
                                         due: cyc + lat_min + int'($urandom_range(lat_max - lat_min))});
                        model_pc += 64'd4;
                        grants++;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        int d0, g0;
        #2;
        chk("rst_valid", 64'(instr_valid_o), 0);
        chk("rst_req", 64'(imem_req_o), 0);
        chk("rst_instr", 64'(instr_o), 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_pc4", pc_4_o, 0);

        // streaming at full rate
        apply_reset();
        drive_cycle(); #1;
        chk("first_valid_c2", 64'(instr_valid_o), 0);
        drive_cycle(); #1;
        chk("first_valid_c3", 64'(instr_valid_o), 1);
        chk("first_pc", pc_o, START);
        chk("first_pc4", pc_4_o, START + 64'd4);
        d0 = delivered;
        repeat (10) drive_cycle();
        #1 chk("throughput", 64'(delivered - d0), 10);

        // decode stalled: queue fills, requests stop
        rdy_pct = 0;
        apply_reset();
        g0 = grants;
        repeat (10) drive_cycle();
        #1;
        chk("stall_grants", 64'(grants - g0), 4);
        chk("stall_req_low", 64'(imem_req_o), 0);
        chk("stall_head_pc", pc_o, START);
        rdy_pct = 100;
        repeat (12) drive_cycle();

        // redirect with three requests in flight, one returning that cycle
        lat_min = 3; lat_max = 3;
        gnt_budget = grants + 3;
        redir_on_rsp = 1'b1; redir_on_rsp_tgt = 64'h2002;
        apply_reset();
        for (int i = 0; i < 20 && redir_on_rsp; i++) drive_cycle();
        chk("redir_fired", 64'(redir_on_rsp), 0);
        gnt_budget = BIG; lat_min = 1; lat_max = 1;
        drive_cycle(); #1;
        chk("redir_q_empty", 64'(instr_valid_o), 0);
        chk("redir_addr", imem_addr_o, 64'h2000);
        repeat (15) drive_cycle();

        // grant withheld: address held stable
        gnt_budget = grants;
        apply_reset();
        repeat (5) begin
            drive_cycle(); #1;
            chk("nognt_req", 64'(imem_req_o), 1);
            chk("nognt_addr", imem_addr_o, START);
            chk("nognt_valid", 64'(instr_valid_o), 0);
        end
        gnt_budget = BIG;
        repeat (10) drive_cycle();

        // back-to-back redirects, last target wins
        lat_min = 1; lat_max = 3;
        repeat (6) drive_cycle();
        drive_cycle(1'b1, 64'h3000);
        drive_cycle(1'b1, 64'h4000);
        drive_cycle(); #1;
        chk("b2b_addr", imem_addr_o, 64'h4000);
        repeat (20) drive_cycle();

        // asynchronous reset with a full queue
        rdy_pct = 0; lat_min = 1; lat_max = 1;
        repeat (8) drive_cycle();
        #1 chk("full_valid", 64'(instr_valid_o), 1);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_valid", 64'(instr_valid_o), 0);
        chk("arst_req", 64'(imem_req_o), 0);
        chk("arst_instr", 64'(instr_o), 0);
        chk("arst_pc", pc_o, 0);
        chk("arst_pc4", pc_4_o, 0);
        rdy_pct = 100;
        repeat (2) drive_cycle();
        rst_i = 1'b0;
        #1 chk("restart_addr", imem_addr_o, START);
        repeat (10) drive_cycle();

        // randomized traffic with occasional redirects, including near wrap
        gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 3;
        drive_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF5);
        repeat (1500) begin
            if ($urandom_range(99) < 3) drive_cycle(1'b1, {$urandom, $urandom});
            else                        drive_cycle();
        end

        // drain
        gnt_budget = grants; rdy_pct = 100;
        repeat (30) drive_cycle();
        #1;
        chk("drain_valid", 64'(instr_valid_o), 0);
        chk("drain_scoreboard", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
